// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states,
// opcodes, ALU operation codes and datapath mux select values.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;

   localparam logic [1:0] SRCB_WDATA = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller is the master: it reads instruction fields and the
// zero flag, and drives every select and write strobe.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       RegWrite;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, RegWrite, instr_done, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, RegWrite, instr_done, illegal
   );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: turns the FSM's ALUOp plus instruction fields into the
// ALU operation code. Unsupported funct3 values quietly fall back to add.
module mc_aludec
   import mc_pkg::*;
(
   input  logic [1:0] i_aluOp,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_opb5,
   output logic [2:0] o_aluControl
);

   // Only R-type (op[5]=1) with funct7b5 set means sub; addi never subtracts
   always_comb begin
      o_aluControl = ALU_ADD;
      case (i_aluOp)
         ALUOP_ADD: o_aluControl = ALU_ADD;
         ALUOP_SUB: o_aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               3'b000:  o_aluControl = (i_funct7b5 & i_opb5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_aluControl = ALU_SLT;
               3'b110:  o_aluControl = ALU_OR;
               3'b111:  o_aluControl = ALU_AND;
               default: o_aluControl = ALU_ADD;
            endcase
         end
         default: o_aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath. One state per
// cycle; strobes are masked while reset is held so an aborted
// instruction never writes anything.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   multicycle_controller_if.master bus
);

   state_t     r_state;
   state_t     w_nextState;

   logic       w_pcUpdate;
   logic       w_branch;
   logic       w_adrSrc;
   logic       w_memWrite;
   logic       w_irWrite;
   logic       w_regWrite;
   logic       w_instrDone;
   logic       w_illegal;
   logic [1:0] w_resultSrc;
   logic [1:0] w_aluSrcA;
   logic [1:0] w_aluSrcB;
   logic [1:0] w_aluOp;
   logic [1:0] w_immSrc;
   logic [2:0] w_aluControl;

   // State register; reset always restarts at FETCH
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_FETCH;
      else       r_state <= w_nextState;
   end

   // Next-state logic; op comes from the IR and is only trusted from DECODE on
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_FETCH:  w_nextState = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: w_nextState = S_MEMADR;
               OP_R:         w_nextState = S_EXECUTER;
               OP_I:         w_nextState = S_EXECUTEI;
               OP_BEQ:       w_nextState = S_BEQ;
               OP_JAL:       w_nextState = S_JAL;
               default:      w_nextState = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   w_nextState = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  w_nextState = S_MEMWB;
         S_MEMWB:    w_nextState = S_FETCH;
         S_MEMWRITE: w_nextState = S_FETCH;
         S_EXECUTER: w_nextState = S_ALUWB;
         S_EXECUTEI: w_nextState = S_ALUWB;
         S_ALUWB:    w_nextState = S_FETCH;
         S_BEQ:      w_nextState = S_FETCH;
         S_JAL:      w_nextState = S_ALUWB;
         S_ILLEGAL:  w_nextState = S_ILLEGAL;
         default:    w_nextState = S_ILLEGAL;
      endcase
   end

   // Moore output decode; anything a state does not mention stays 0 / 00
   always_comb begin
      w_pcUpdate  = 1'b0;
      w_branch    = 1'b0;
      w_adrSrc    = 1'b0;
      w_memWrite  = 1'b0;
      w_irWrite   = 1'b0;
      w_regWrite  = 1'b0;
      w_instrDone = 1'b0;
      w_illegal   = 1'b0;
      w_resultSrc = RES_ALUOUT;
      w_aluSrcA   = SRCA_PC;
      w_aluSrcB   = SRCB_WDATA;
      w_aluOp     = ALUOP_ADD;
      case (r_state)
         S_FETCH: begin
            w_irWrite   = 1'b1;
            w_aluSrcB   = SRCB_FOUR;
            w_resultSrc = RES_ALURESULT;
            w_pcUpdate  = 1'b1;
         end
         S_DECODE: begin
            w_aluSrcA = SRCA_OLDPC;
            w_aluSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            w_aluSrcA = SRCA_REGA;
            w_aluSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            w_adrSrc = 1'b1;
         end
         S_MEMWB: begin
            w_resultSrc = RES_DATA;
            w_regWrite  = 1'b1;
            w_instrDone = 1'b1;
         end
         S_MEMWRITE: begin
            w_adrSrc    = 1'b1;
            w_memWrite  = 1'b1;
            w_instrDone = 1'b1;
         end
         S_EXECUTER: begin
            w_aluSrcA = SRCA_REGA;
            w_aluOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            w_aluSrcA = SRCA_REGA;
            w_aluSrcB = SRCB_IMM;
            w_aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            w_regWrite  = 1'b1;
            w_instrDone = 1'b1;
         end
         S_BEQ: begin
            w_aluSrcA   = SRCA_REGA;
            w_aluOp     = ALUOP_SUB;
            w_branch    = 1'b1;
            w_instrDone = 1'b1;
         end
         S_JAL: begin
            w_aluSrcA  = SRCA_OLDPC;
            w_aluSrcB  = SRCB_FOUR;
            w_pcUpdate = 1'b1;
         end
         S_ILLEGAL: begin
            w_illegal = 1'b1;
         end
         default: begin
            w_illegal = 1'b1;
         end
      endcase
   end

   // Immediate format follows the opcode directly, independent of state
   always_comb begin
      w_immSrc = IMM_I;
      case (bus.op)
         OP_LW, OP_I: w_immSrc = IMM_I;
         OP_SW:       w_immSrc = IMM_S;
         OP_BEQ:      w_immSrc = IMM_B;
         OP_JAL:      w_immSrc = IMM_J;
         default:     w_immSrc = IMM_I;
      endcase
   end

   mc_aludec u_aludec (
      .i_aluOp      (w_aluOp),
      .i_funct3     (bus.funct3),
      .i_funct7b5   (bus.funct7b5),
      .i_opb5       (bus.op[5]),
      .o_aluControl (w_aluControl)
   );

   assign bus.PCWrite    = ~reset & ((w_branch & bus.zero) | w_pcUpdate);
   assign bus.IRWrite    = ~reset & w_irWrite;
   assign bus.RegWrite   = ~reset & w_regWrite;
   assign bus.MemWrite   = ~reset & w_memWrite;
   assign bus.instr_done = ~reset & w_instrDone;
   assign bus.AdrSrc     = w_adrSrc;
   assign bus.illegal    = w_illegal;
   assign bus.ResultSrc  = w_resultSrc;
   assign bus.ALUSrcA    = w_aluSrcA;
   assign bus.ALUSrcB    = w_aluSrcB;
   assign bus.ImmSrc     = w_immSrc;
   assign bus.ALUControl = w_aluControl;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full control word against hand-derived
// per-state values.
module tb_multicycle_controller;

   logic clk;
   logic reset;
   int   checkCount;
   int   errorCount;

   multicycle_controller_if busIf ();

   multicycle_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (busIf)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word layout:
   // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal,
   //  ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
   localparam logic [15:0] E_FETCH_RST = {7'b0000000, 2'b10, 2'b00, 2'b10, 3'b000};
   localparam logic [15:0] E_FETCH     = {7'b1001000, 2'b10, 2'b00, 2'b10, 3'b000};
   localparam logic [15:0] E_DECODE    = {7'b0000000, 2'b00, 2'b01, 2'b01, 3'b000};
   localparam logic [15:0] E_MEMADR    = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b000};
   localparam logic [15:0] E_MEMREAD   = {7'b0100000, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] E_MEMWB     = {7'b0000110, 2'b01, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] E_MEMWRITE  = {7'b0110010, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] E_ALUWB     = {7'b0000110, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] E_BEQ_TAKEN = {7'b1000010, 2'b00, 2'b10, 2'b00, 3'b001};
   localparam logic [15:0] E_BEQ_NOT   = {7'b0000010, 2'b00, 2'b10, 2'b00, 3'b001};
   localparam logic [15:0] E_JAL       = {7'b1000000, 2'b00, 2'b01, 2'b10, 3'b000};
   localparam logic [15:0] E_ILLEGAL   = {7'b0000001, 2'b00, 2'b00, 2'b00, 3'b000};
   localparam logic [15:0] E_EXR_SUB   = {7'b0000000, 2'b00, 2'b10, 2'b00, 3'b001};
   localparam logic [15:0] E_EXR_AND   = {7'b0000000, 2'b00, 2'b10, 2'b00, 3'b010};
   localparam logic [15:0] E_EXR_OR    = {7'b0000000, 2'b00, 2'b10, 2'b00, 3'b011};
   localparam logic [15:0] E_EXI_ADD   = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b000};
   localparam logic [15:0] E_EXI_SLT   = {7'b0000000, 2'b00, 2'b10, 2'b01, 3'b101};

   // Packs the DUT's live control outputs into the layout above
   function automatic logic [15:0] packObs();
      return {busIf.PCWrite, busIf.AdrSrc, busIf.MemWrite, busIf.IRWrite,
              busIf.RegWrite, busIf.instr_done, busIf.illegal,
              busIf.ResultSrc, busIf.ALUSrcA, busIf.ALUSrcB, busIf.ALUControl};
   endfunction

   // Counts one comparison and reports it if the values differ
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
      end
   endtask

   // Loads the instruction fields and zero flag seen by the controller
   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic f7b5, input logic zero);
      busIf.op       = op;
      busIf.funct3   = f3;
      busIf.funct7b5 = f7b5;
      busIf.zero     = zero;
   endtask

   // Advances one clock and settles just after the edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Stimulus sequence
   initial begin
      checkCount = 0;
      errorCount = 0;
      reset      = 1'b1;
      applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);

      repeat (3) begin
         stepCycle();
         checkOutput("reset_hold", packObs(), E_FETCH_RST);
      end

      // lw: FETCH DECODE MEMADR MEMREAD MEMWB
      reset = 1'b0;
      applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
      #1;
      checkOutput("lw_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("lw_decode", packObs(), E_DECODE);
      checkOutput("lw_imm", {14'b0, busIf.ImmSrc}, 16'd0);
      stepCycle(); checkOutput("lw_memadr", packObs(), E_MEMADR);
      stepCycle(); checkOutput("lw_memread", packObs(), E_MEMREAD);
      stepCycle(); checkOutput("lw_memwb", packObs(), E_MEMWB);
      stepCycle();

      // sw: FETCH DECODE MEMADR MEMWRITE
      applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
      checkOutput("sw_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("sw_decode", packObs(), E_DECODE);
      checkOutput("sw_imm", {14'b0, busIf.ImmSrc}, 16'd1);
      stepCycle(); checkOutput("sw_memadr", packObs(), E_MEMADR);
      stepCycle(); checkOutput("sw_memwrite", packObs(), E_MEMWRITE);
      stepCycle();

      // beq taken
      applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
      checkOutput("beqT_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("beqT_decode", packObs(), E_DECODE);
      checkOutput("beq_imm", {14'b0, busIf.ImmSrc}, 16'd2);
      stepCycle(); checkOutput("beqT_beq", packObs(), E_BEQ_TAKEN);
      stepCycle();

      // beq not taken
      applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
      checkOutput("beqN_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("beqN_decode", packObs(), E_DECODE);
      stepCycle(); checkOutput("beqN_beq", packObs(), E_BEQ_NOT);
      stepCycle();

      // R-type sub
      applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
      checkOutput("sub_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("sub_decode", packObs(), E_DECODE);
      stepCycle(); checkOutput("sub_execr", packObs(), E_EXR_SUB);
      stepCycle(); checkOutput("sub_aluwb", packObs(), E_ALUWB);
      stepCycle();

      // addi with funct7b5 set must still add
      applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0);
      checkOutput("addi_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("addi_decode", packObs(), E_DECODE);
      checkOutput("addi_imm", {14'b0, busIf.ImmSrc}, 16'd0);
      stepCycle(); checkOutput("addi_execi", packObs(), E_EXI_ADD);
      stepCycle(); checkOutput("addi_aluwb", packObs(), E_ALUWB);
      stepCycle();

      // R-type and
      applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0);
      checkOutput("and_fetch", packObs(), E_FETCH);
      stepCycle(); stepCycle(); checkOutput("and_execr", packObs(), E_EXR_AND);
      stepCycle(); stepCycle();

      // R-type or
      applyStimulus(7'b0110011, 3'b110, 1'b0, 1'b0);
      stepCycle(); stepCycle(); checkOutput("or_execr", packObs(), E_EXR_OR);
      stepCycle(); stepCycle();

      // slti
      applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b0);
      stepCycle(); stepCycle(); checkOutput("slti_execi", packObs(), E_EXI_SLT);
      stepCycle(); stepCycle();

      // jal: FETCH DECODE JAL ALUWB
      applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
      checkOutput("jal_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("jal_decode", packObs(), E_DECODE);
      checkOutput("jal_imm", {14'b0, busIf.ImmSrc}, 16'd3);
      stepCycle(); checkOutput("jal_jal", packObs(), E_JAL);
      stepCycle(); checkOutput("jal_aluwb", packObs(), E_ALUWB);
      stepCycle();

      // Unknown opcode locks up in ILLEGAL
      applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b1);
      checkOutput("ill_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("ill_decode", packObs(), E_DECODE);
      for (int i = 0; i < 10; i++) begin
         stepCycle();
         checkOutput("ill_hold", packObs(), E_ILLEGAL);
      end

      // Reset recovers from ILLEGAL
      reset = 1'b1;
      stepCycle(); checkOutput("ill_reset", packObs(), E_FETCH_RST);

      // lw aborted by reset during MEMREAD
      reset = 1'b0;
      applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
      #1;
      checkOutput("abort_fetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("abort_decode", packObs(), E_DECODE);
      stepCycle(); checkOutput("abort_memadr", packObs(), E_MEMADR);
      stepCycle(); checkOutput("abort_memread", packObs(), E_MEMREAD);
      reset = 1'b1;
      #1;
      checkOutput("abort_memread_rst", packObs(), E_MEMREAD);
      stepCycle(); checkOutput("abort_no_memwb", packObs(), E_FETCH_RST);
      reset = 1'b0;
      #1;
      checkOutput("abort_refetch", packObs(), E_FETCH);
      stepCycle(); checkOutput("abort_redecode", packObs(), E_DECODE);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences a multicycle RV32I datapath (shared instruction/data memory, registered IR, OldPC, A, WriteData, ALUOut and Data). It replaces the single-cycle combinational controller when the core moves to the multicycle organisation. It issues one Moore state per cycle and drives every mux select and write strobe of the datapath. It supports lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq and jal.

## Interface
- No parameters; encodings live in the shared package.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- op  in  7  opcode from registered IR (Instr[6:0]).
- funct3  in  3  IR[14:12].
- funct7b5  in  1  IR[30].
- zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable, computed as (Branch & zero) | PCUpdate.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  SrcA select: 00 = PC, 01 = OldPC, 10 = A.
- ALUSrcB  out  2  SrcB select: 00 = WriteData, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- RegWrite  out  1  register file write strobe.
- instr_done  out  1  1-cycle pulse in the final state of each instruction.
- illegal  out  1  high while in ILLEGAL.

## Operation
- States and outputs. Strobes not listed are 0, and selects not listed are 00.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut holds the branch target. Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other op → ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op=lw, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Goes to FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1. Goes to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Goes to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Goes to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB, which writes PC+4.
  - ILLEGAL: all strobes 0, illegal=1. Stays in ILLEGAL until reset.
- ImmSrc is combinational from op: lw and I-type = 00, sw = 01, beq = 10, jal = 11, other op = 00.
- ALUControl:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10 → decode funct3:
    - 000: sub iff funct7b5 & op[5], else add
    - 010: slt
    - 110: or
    - 111: and
    - other funct3: add, with no trap

## Timing
- Reset:
  - A posedge with reset=1 loads FETCH.
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and instr_done are forced to 0, regardless of state.
  - The first fetch strobe occurs in the first cycle with reset=0.
- Reset mid-instruction aborts the instruction immediately. No further strobe of the aborted instruction is issued.
- The next-state transition uses op as registered in IR. op is valid from DECODE onward and is ignored in FETCH.
- Latency in cycles from FETCH up to and including the last state:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - jal: 4
  - beq: 3
- Every instruction returns to FETCH the cycle after its instr_done pulse. There are no idle cycles between instructions.
- PCWrite is combinational on zero only in BEQ. In all other states it equals PCUpdate.

## Structure
- Package mc_pkg holds:
  - the state enum typedef (4-bit)
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - ALUControl codes
  - ResultSrc, ALUSrcA and ALUSrcB select constants
- The top module holds the state register, next-state logic and the Moore output decode. It also holds the ImmSrc decode.
- One sub-module, mc_aludec: combinational ALUOp/funct3/funct7b5/op[5] → ALUControl.

## Test plan
- Reset held 3 cycles, then released:
  - no strobe while reset=1
  - next cycle is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10
- op=0000011 (lw):
  - state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB
  - RegWrite=1 and ResultSrc=01 only in cycle 5
  - instr_done pulses in cycle 5
- op=0100011 (sw): MemWrite=1, AdrSrc=1 in cycle 4 only; RegWrite never asserts.
- op=1100011 (beq):
  - zero=1 in cycle 3 → PCWrite=1 and ALUControl=001
  - zero=0 → PCWrite=0
  - next cycle is FETCH in both cases
- op=0110011 with funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER. Same funct3/funct7b5 with op=0010011 (addi) → 000.
- op=1111111 → ILLEGAL from cycle 3 with all strobes 0 for 10 cycles. Reset asserted in the middle of a lw's MEMREAD → no MemWB write, then FETCH after release.
